// File: rtl/level_sequencer.sv
// -----------------------------------------------------------------------------
// level_sequencer
//   Game-flow controller sitting downstream of the per-level modules. It
//   watches win/lose from the active level, pauses for HOLD_CYCLES between
//   levels, advances the level index or spends a life, and holds the active
//   level in reset (level_reset_n=0) whenever the game is not in S_PLAY.
//
// Optional feature macro: LEVEL_SEQ_SKIP_EN
//   When defined, adds input skip_button. A rising edge while playing acts
//   exactly like a win (debug aid). When undefined the port does not exist.
//
// Ports
//   vga_clock      in   pixel clock, all state on posedge
//   reset          in   asynchronous, active-low
//   start_button   in   active-high level, rising edge detected here
//   win / lose     in   level-sensitive results from the active level
//   skip_button    in   (LEVEL_SEQ_SKIP_EN only) debug skip, edge detected
//   level_reset_n  out  0 = hold active level in reset (registered)
//   level_index    out  current level
//   lives          out  remaining lives
//   game_state     out  encoded FSM state for HUD/LEDs
//   game_won       out  high in S_WON
//   game_over      out  high in S_OVER
// -----------------------------------------------------------------------------
module level_sequencer #(
  parameter int NUM_LEVELS  = 4,
  parameter int START_LIVES = 3,
  parameter int HOLD_CYCLES = 25_000_000
) (
  input  logic                                                  vga_clock,
  input  logic                                                  reset,
  input  logic                                                  start_button,
  input  logic                                                  win,
  input  logic                                                  lose,
`ifdef LEVEL_SEQ_SKIP_EN
  input  logic                                                  skip_button,
`endif
  output logic                                                  level_reset_n,
  output logic [((NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1)-1:0] level_index,
  output logic [2:0]                                            lives,
  output logic [2:0]                                            game_state,
  output logic                                                  game_won,
  output logic                                                  game_over
);

  localparam int IDX_W = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1;
  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_LEVELS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [2:0]       LIVES_INIT = 3'(START_LIVES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_WIN_HOLD  = 3'd2,
    S_LOSE_HOLD = 3'd3,
    S_WON       = 3'd4,
    S_OVER      = 3'd5
  } state_t;

  state_t           r_state;
  logic             r_start_q;
  logic [IDX_W-1:0] r_idx;
  logic [2:0]       r_lives;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level_reset_n;
  logic             r_game_won;
  logic             r_game_over;

  state_t           w_state_nxt;
  logic [IDX_W-1:0] w_idx_nxt;
  logic [2:0]       w_lives_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_start_edge;
  logic             w_advance;

  assign w_start_edge = start_button & ~r_start_q;

`ifdef LEVEL_SEQ_SKIP_EN
  logic r_skip_q;
  logic w_skip_edge;

  assign w_skip_edge = skip_button & ~r_skip_q;
  assign w_advance   = win | w_skip_edge;

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) r_skip_q <= 1'b0;
    else        r_skip_q <= skip_button;
  end
`else
  assign w_advance = win;
`endif

  // Next-state logic. The hold counter only runs in the hold states and is
  // cleared on the exit cycle, so each pause is exactly HOLD_CYCLES long.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_lives_nxt = r_lives;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE, S_WON, S_OVER: begin
        if (w_start_edge) begin
          w_state_nxt = S_PLAY;
          w_idx_nxt   = '0;
          w_lives_nxt = LIVES_INIT;
          w_cnt_nxt   = '0;
        end
      end
      S_PLAY: begin
        // win takes priority over lose so a simultaneous pair costs no life
        if (w_advance) begin
          w_state_nxt = S_WIN_HOLD;
          w_cnt_nxt   = '0;
        end else if (lose) begin
          w_state_nxt = S_LOSE_HOLD;
          w_cnt_nxt   = '0;
          if (r_lives != 3'd0) w_lives_nxt = r_lives - 3'd1;
        end
      end
      S_WIN_HOLD: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt = '0;
          if (r_idx == LAST_IDX) begin
            w_state_nxt = S_WON;
          end else begin
            w_idx_nxt   = r_idx + IDX_W'(1);
            w_state_nxt = S_PLAY;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_LOSE_HOLD: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = (r_lives == 3'd0) ? S_OVER : S_PLAY;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with
  // r_state and are glitch-free toward the level modules.
  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      r_state         <= S_IDLE;
      r_start_q       <= 1'b0;
      r_idx           <= '0;
      r_lives         <= LIVES_INIT;
      r_cnt           <= '0;
      r_level_reset_n <= 1'b0;
      r_game_won      <= 1'b0;
      r_game_over     <= 1'b0;
    end else begin
      r_state         <= w_state_nxt;
      r_start_q       <= start_button;
      r_idx           <= w_idx_nxt;
      r_lives         <= w_lives_nxt;
      r_cnt           <= w_cnt_nxt;
      r_level_reset_n <= (w_state_nxt == S_PLAY);
      r_game_won      <= (w_state_nxt == S_WON);
      r_game_over     <= (w_state_nxt == S_OVER);
    end
  end

  assign level_reset_n = r_level_reset_n;
  assign level_index   = r_idx;
  assign lives         = r_lives;
  assign game_state    = r_state;
  assign game_won      = r_game_won;
  assign game_over     = r_game_over;

endmodule
